// File: rtl/ysyx_ifu_mem_resp_pkg.sv
// ysyx_ifu_mem_resp_pkg
//   Shared definitions for the IFU/LSU instruction-memory responders:
//   responder FSM state encodings, the default memory base address, the
//   latency-counter width and the illegal-address check.
package ysyx_ifu_mem_resp_pkg;

  typedef enum logic [1:0] {
    ysyx_MR_IDLE  = 2'd0,
    ysyx_MR_BUSY  = 2'd1,
    ysyx_MR_RESP  = 2'd2,
    ysyx_MR_DRAIN = 2'd3
  } ysyx_mr_state_e;

  localparam logic [31:0] YSYX_MR_MEM_BASE = 32'h8000_0000;

  // LATENCY is limited to 1..15, so a 4-bit down-counter is enough.
  localparam int YSYX_MR_CNT_W = 4;

  // An address is illegal when it is not word aligned or falls outside
  // [base, base + span). Evaluated in 64 bits so base + span cannot wrap.
  function automatic logic ysyx_mr_addr_illegal(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [63:0] span,
    input int unsigned off_w
  );
    logic [63:0] mask;
    mask = (64'd1 << off_w) - 64'd1;
    return ((addr & mask) != 64'd0) || (addr < base) || (addr >= base + span);
  endfunction

endpackage

// File: rtl/ysyx_ifu_mem_resp_if.sv
// ysyx_ifu_mem_resp_if
//   IFU instruction-fetch read channel.
//   master (IFU)       : drives ifu_araddr / ifu_arvalid, receives response
//   slave  (responder) : receives request, drives ifu_rdata / ifu_rvalid / ifu_rerr
//   ifu_arvalid is a level request; ifu_rvalid is a one-cycle pulse and
//   ifu_rerr qualifies it.
interface ysyx_ifu_mem_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ifu_araddr;
  logic              ifu_arvalid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_rvalid;
  logic              ifu_rerr;

  modport master (
    output ifu_araddr, ifu_arvalid,
    input  ifu_rdata, ifu_rvalid, ifu_rerr
  );

  modport slave (
    input  ifu_araddr, ifu_arvalid,
    output ifu_rdata, ifu_rvalid, ifu_rerr
  );
endinterface

// File: rtl/ysyx_ifu_mem_array.sv
// ysyx_ifu_mem_array
//   MEM_WORDS x DATA_W storage, one synchronous write port and one
//   combinational read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable; widx/wdata written at the rising edge
//   ridx  : read index; rdata follows it combinationally
module ysyx_ifu_mem_array #(
  parameter  int MEM_WORDS = 1024,
  parameter  int DATA_W    = 32,
  localparam int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Read happens before the write at the same edge lands, so a write that
  // collides with a response returns the old word.
  assign rdata = mem[ridx];

endmodule

// File: rtl/ysyx_ifu_mem_resp.sv
// ysyx_ifu_mem_resp
//   Fixed-latency instruction-memory responder at the far end of the IFU
//   fetch channel. Accepts a word read, answers LATENCY cycles after the
//   accept edge with a one-cycle ifu_rvalid pulse, flags misaligned or
//   out-of-range addresses with ifu_rerr.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   ifu        : fetch channel (slave side)
//   init_*     : preload write port into the memory, usable in any state
//   served_cnt : number of responses issued, saturating
module ysyx_ifu_mem_resp
  import ysyx_ifu_mem_resp_pkg::*;
#(
  parameter  int          ADDR_W    = 32,
  parameter  int          DATA_W    = 32,
  parameter  int          MEM_WORDS = 1024,
  parameter  logic [31:0] MEM_BASE  = YSYX_MR_MEM_BASE,
  parameter  int          LATENCY   = 2,
  localparam int          IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  ysyx_ifu_mem_resp_if.slave ifu,
  input  logic              init_we,
  input  logic [IDX_W-1:0]  init_idx,
  input  logic [DATA_W-1:0] init_wdata,
  output logic [31:0]       served_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam ysyx_mr_state_e ACCEPT_STATE = (LATENCY == 1) ? ysyx_MR_RESP : ysyx_MR_BUSY;
  localparam logic [YSYX_MR_CNT_W-1:0] CNT_LOAD = YSYX_MR_CNT_W'(LATENCY - 1);

  ysyx_mr_state_e           state_reg, state_next;
  logic [YSYX_MR_CNT_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0]        req_addr_reg, req_addr_next;
  logic [DATA_W-1:0]        rdata_reg, rdata_next;
  logic                     rvalid_reg, rvalid_next;
  logic                     rerr_reg, rerr_next;
  logic [31:0]              served_cnt_reg, served_cnt_next;

  logic                     accept;
  logic                     enter_resp;
  logic [ADDR_W-1:0]        resp_addr;
  logic [ADDR_W-1:0]        resp_off;
  logic [IDX_W-1:0]         rd_idx;
  logic [DATA_W-1:0]        rd_data;
  logic                     resp_err;

  // DRAIN only re-accepts when the address moved, so a held arvalid for the
  // address just served does not produce a second response.
  assign accept = ifu.ifu_arvalid &&
                  ((state_reg == ysyx_MR_IDLE) ||
                   ((state_reg == ysyx_MR_DRAIN) && (ifu.ifu_araddr != req_addr_reg)));

  // With LATENCY==1 the response is formed at the accept edge itself, before
  // req_addr has captured the request, so the live address is used then.
  assign resp_addr = accept ? ifu.ifu_araddr : req_addr_reg;
  assign resp_off  = resp_addr - ADDR_W'(MEM_BASE);
  assign rd_idx    = resp_off[OFF_W +: IDX_W];
  assign resp_err  = ysyx_mr_addr_illegal(64'(resp_addr), 64'(MEM_BASE),
                                          64'(MEM_WORDS) * 64'(BYTES), OFF_W);

  ysyx_ifu_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .DATA_W    (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (init_we),
    .widx  (init_idx),
    .wdata (init_wdata),
    .ridx  (rd_idx),
    .rdata (rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ysyx_MR_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ysyx_MR_IDLE:  if (accept) state_next = ACCEPT_STATE;
      ysyx_MR_BUSY:  if (cnt_reg == YSYX_MR_CNT_W'(1)) state_next = ysyx_MR_RESP;
      ysyx_MR_RESP:  state_next = ysyx_MR_DRAIN;
      ysyx_MR_DRAIN: begin
        if (accept) begin
          state_next = ACCEPT_STATE;
        end else if (!ifu.ifu_arvalid) begin
          state_next = ysyx_MR_IDLE;
        end
      end
      default:       state_next = ysyx_MR_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    enter_resp      = (state_next == ysyx_MR_RESP);
    req_addr_next   = accept ? ifu.ifu_araddr : req_addr_reg;
    cnt_next        = cnt_reg;
    if (accept) begin
      cnt_next = CNT_LOAD;
    end else if (state_reg == ysyx_MR_BUSY) begin
      cnt_next = cnt_reg - YSYX_MR_CNT_W'(1);
    end
    rvalid_next     = enter_resp;
    rerr_next       = enter_resp && resp_err;
    rdata_next      = rdata_reg;
    served_cnt_next = served_cnt_reg;
    if (enter_resp) begin
      rdata_next = resp_err ? '0 : rd_data;
      if (served_cnt_reg != 32'hFFFF_FFFF) begin
        served_cnt_next = served_cnt_reg + 32'd1;
      end
    end
  end

  // Datapath / output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg        <= '0;
      req_addr_reg   <= '0;
      rdata_reg      <= '0;
      rvalid_reg     <= 1'b0;
      rerr_reg       <= 1'b0;
      served_cnt_reg <= '0;
    end else begin
      cnt_reg        <= cnt_next;
      req_addr_reg   <= req_addr_next;
      rdata_reg      <= rdata_next;
      rvalid_reg     <= rvalid_next;
      rerr_reg       <= rerr_next;
      served_cnt_reg <= served_cnt_next;
    end
  end

  assign ifu.ifu_rdata  = rdata_reg;
  assign ifu.ifu_rvalid = rvalid_reg;
  assign ifu.ifu_rerr   = rerr_reg;
  assign served_cnt     = served_cnt_reg;

endmodule

// File: tb/tb_ysyx_ifu_mem_resp.sv
// tb_ysyx_ifu_mem_resp
//   Four responders (LATENCY 2, 1, 4, 15) share the preload port and reset;
//   each has its own fetch channel. Stimulus pushes the expected response
//   (data, err, cycle) into that responder's queue; a per-responder monitor
//   pops and compares on every rvalid pulse.
module tb_ysyx_ifu_mem_resp;

  localparam logic [3:0][3:0] LATS = {4'd15, 4'd4, 4'd1, 4'd2};

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_we = 1'b0;
  logic [9:0]  init_idx = '0;
  logic [31:0] init_wdata = '0;
  logic [31:0] araddr_v [4];
  logic        arvalid_v [4];
  logic [31:0] served [4];
  logic        rvalid_mon [4];
  logic        rerr_mon [4];
  logic [31:0] rdata_mon [4];

  exp_t exp_q [4][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    ysyx_ifu_mem_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assign bus.ifu_araddr  = araddr_v[gi];
    assign bus.ifu_arvalid = arvalid_v[gi];
    assign rvalid_mon[gi]  = bus.ifu_rvalid;
    assign rerr_mon[gi]    = bus.ifu_rerr;
    assign rdata_mon[gi]   = bus.ifu_rdata;

    ysyx_ifu_mem_resp #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .MEM_WORDS (1024),
      .MEM_BASE  (32'h8000_0000),
      .LATENCY   (int'(LATS[gi]))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .ifu        (bus),
      .init_we    (init_we),
      .init_idx   (init_idx),
      .init_wdata (init_wdata),
      .served_cnt (served[gi])
    );

    always @(negedge clk) begin : mon
      exp_t e;
      if (bus.ifu_rvalid) begin
        if (exp_q[gi].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid dut%0d cyc %0d got rdata %h required no pulse",
                   gi, cyc, bus.ifu_rdata);
        end else begin
          e = exp_q[gi].pop_front();
          $display("dut%0d lat %0d cyc %0d rdata %h rerr %0d (exp %h/%0d @%0d)",
                   gi, LATS[gi], cyc, bus.ifu_rdata, bus.ifu_rerr, e.data, e.err, e.cyc);
          check($sformatf("rdata_dut%0d", gi), bus.ifu_rdata, e.data);
          check($sformatf("rerr_dut%0d", gi), 32'(bus.ifu_rerr), 32'(e.err));
          check($sformatf("cycle_dut%0d", gi), cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(logic [9:0] idx, logic [31:0] data);
    @(negedge clk);
    init_we = 1'b1; init_idx = idx; init_wdata = data;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  // Raise (or re-point) a request; accept lands on the next edge, so the
  // response is due LATENCY-1 edges after that.
  task automatic issue(int k, logic [31:0] a, logic [31:0] d, logic e, bit want);
    @(negedge clk);
    araddr_v[k]  = a;
    arvalid_v[k] = 1'b1;
    if (want) exp_q[k].push_back('{d, e, cyc + int'(LATS[k])});
  endtask

  task automatic drop(int k);
    @(negedge clk);
    arvalid_v[k] = 1'b0;
    wait_n(2);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      araddr_v[k] = '0; arvalid_v[k] = 1'b0;
    end
    wait_n(2);
    check("reset_rvalid", 32'(rvalid_mon[0]), 32'd0);
    check("reset_rerr", 32'(rerr_mon[0]), 32'd0);
    check("reset_rdata", rdata_mon[0], 32'd0);
    check("reset_served", served[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;

    preload(10'd0, 32'h0000_0413);
    preload(10'd1, 32'h0010_0093);
    preload(10'd3, 32'hAAAA_0003);
    preload(10'd5, 32'h0050_0293);
    preload(10'd6, 32'h0060_0313);

    // Held request: single pulse, then back-to-back accept from DRAIN.
    issue(0, 32'h8000_0000, 32'h0000_0413, 1'b0, 1'b1);
    wait_n(6);
    check("served_after_first", served[0], 32'd1);
    issue(0, 32'h8000_0004, 32'h0010_0093, 1'b0, 1'b1);
    wait_n(5);
    check("served_after_b2b", served[0], 32'd2);
    drop(0);

    // Illegal addresses: misaligned, below base, past end.
    issue(0, 32'h8000_0002, 32'h0, 1'b1, 1'b1); wait_n(4); drop(0);
    issue(0, 32'h7FFF_FFFC, 32'h0, 1'b1, 1'b1); wait_n(4); drop(0);
    issue(0, 32'h8000_1000, 32'h0, 1'b1, 1'b1); wait_n(4); drop(0);

    // Preload to idx 3 on the edge that enters RESP: old word returned.
    issue(0, 32'h8000_000C, 32'hAAAA_0003, 1'b0, 1'b1);
    preload(10'd3, 32'h5555_0003);
    wait_n(3); drop(0);
    issue(0, 32'h8000_000C, 32'h5555_0003, 1'b0, 1'b1);
    wait_n(4); drop(0);
    check("served_before_reset", served[0], 32'd7);

    // Asynchronous reset one cycle after accept drops the request.
    issue(0, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_served", served[0], 32'd0);
    check("async_reset_rvalid", 32'(rvalid_mon[0]), 32'd0);
    arvalid_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_n(6);
    check("served_after_reset", served[0], 32'd0);
    issue(0, 32'h8000_0000, 32'h0000_0413, 1'b0, 1'b1);
    wait_n(4); drop(0);
    check("served_after_refetch", served[0], 32'd1);

    // Latency sweep; address wiggles during BUSY must not matter.
    for (int k = 1; k < 4; k++) begin
      issue(k, 32'h8000_0014, 32'h0050_0293, 1'b0, 1'b1);
      if (LATS[k] >= 4'd4) begin
        @(negedge clk) araddr_v[k] = 32'h8000_0018;
        @(negedge clk) araddr_v[k] = 32'h8000_0014;
      end
      wait_n(int'(LATS[k]) + 3);
      drop(k);
      check($sformatf("served_sweep_dut%0d", k), served[k], 32'd1);
    end

    wait_n(3);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pending_resp_dut%0d", k), exp_q[k].size(), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_ifu_mem_resp.md
Name: ysyx_ifu_mem_resp

Overview:
- Responder at the far end of the IFU instruction-fetch read channel (araddr/arvalid in, rdata/rvalid out).
- Serves word reads from a local instruction memory after a configurable fixed latency.
- Emits one rvalid pulse per request and flags illegal addresses.
- A preload write port lets the bench or loader fill the memory.
- Used as the IFU's simulation memory and as a tightly-coupled I-ROM model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; word = DATA_W/8 bytes.
- MEM_WORDS, 1024, memory depth in words; power of two.
- MEM_BASE, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from accept edge to the rvalid cycle; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ifu_araddr  in  ADDR_W  fetch byte address.
- ifu_arvalid  in  1  level request; may remain high after the response.
- ifu_rdata  out  DATA_W  fetched word; valid only while ifu_rvalid=1.
- ifu_rvalid  out  1  one-cycle response pulse.
- ifu_rerr  out  1  qualifies ifu_rvalid; address misaligned or out of range.
- init_we  in  1  preload write enable.
- init_idx  in  clog2(MEM_WORDS)  preload word index.
- init_wdata  in  DATA_W  preload data.
- served_cnt  out  32  count of responses issued; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately.
  - ifu_rvalid=0, ifu_rerr=0, ifu_rdata=0, served_cnt=0, latency counter=0.
  - Memory contents are not reset.
  - A request in flight is dropped silently; the IFU re-requests after reset.
- States are IDLE, BUSY, RESP and DRAIN, encoded 2'd0 to 2'd3.
- Accept:
  - Occurs in IDLE when ifu_arvalid=1 at an edge.
  - Captures ifu_araddr into req_addr.
  - Loads cnt <= LATENCY-1.
  - Next state is RESP if LATENCY==1, else BUSY.
- BUSY:
  - cnt decrements each edge; when cnt==1 at an edge, the next state is RESP.
  - ifu_araddr and ifu_arvalid are ignored; the captured address is authoritative.
- Response formation, on the edge entering RESP:
  - err = (req_addr[1:0]!=0) or (req_addr < MEM_BASE) or (req_addr >= MEM_BASE + 4*MEM_WORDS).
  - Word index = (req_addr-MEM_BASE)>>2, taking the low clog2(MEM_WORDS) bits.
  - ifu_rdata <= err ? 0 : mem[idx].
  - ifu_rerr <= err.
  - ifu_rvalid <= 1.
- Latency: with an accept at edge E, ifu_rvalid is high in the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after the accept edge.
- RESP:
  - Lasts exactly one cycle; next state is DRAIN.
  - served_cnt increments on entry, saturating.
  - On leaving RESP: ifu_rvalid=0, ifu_rerr=0; ifu_rdata holds its value.
- DRAIN (prevents re-serving a held arvalid):
  - arvalid=0: go to IDLE.
  - arvalid=1 and araddr==req_addr: stay in DRAIN, no new response.
  - arvalid=1 and araddr!=req_addr: accept directly (same rules as IDLE), with no bubble.
- Preload:
  - init_we=1 writes mem[init_idx] <= init_wdata at the edge, in any state.
  - A write at the same edge that enters RESP for the same index returns the OLD word.
  - A write at an earlier edge is visible.
- Memory array is synchronous-write / combinational-read internally; the registered output stage provides timing.

Decomposition:
- Shared macro header entries:
  - state encodings ysyx_MR_IDLE/BUSY/RESP/DRAIN.
  - default MEM_BASE.
  - an illegal-address check macro reused by the LSU-side responder.
- One sub-module: ysyx_ifu_mem_array.
  - Parameterised MEM_WORDS x DATA_W, 1 write / 1 async read.
  - No reset.
  - The top block owns the FSM, latency counter, error check and output registers.

Test Plan:
- Preload mem[0]=32'h0000_0413; LATENCY=2; arvalid=1 with araddr=32'h8000_0000 accepted at edge 0, held high -> rvalid=1 and rdata=32'h0000_0413 in cycle 2 only; no second pulse while arvalid is held; served_cnt=1.
- Back-to-back: after a response, araddr changes to 32'h8000_0004 with arvalid still high -> accept in DRAIN with no bubble; second rvalid exactly LATENCY cycles later, returning mem[1].
- Errors: araddr=32'h8000_0002 -> rvalid=1, rerr=1, rdata=0; araddr=32'h7FFF_FFFC and 32'h8000_1000 (MEM_WORDS=1024) -> rerr=1.
- Collision: init_we to idx 3 at the same edge RESP is entered for 32'h8000_000C -> old data returned; a repeat fetch after arvalid drops returns the new data.
- Reset mid-BUSY: rst=0 asynchronously one cycle after accept -> rvalid=0 immediately, no pulse after release, served_cnt=0, memory preserved.
- Sweep LATENCY in {1,4,15}: rvalid appears exactly LATENCY cycles after the accept edge; address changes during BUSY do not alter rdata.
